// File: rtl/ascensor_planificador.sv
// ascensor_planificador: N-floor elevator controller with SCAN direction policy,
// door timer, motion watchdog and a latched fault state.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   llamada      call buttons, one bit per floor (level-sampled)
//   sw_piso      floor limit switches, one-hot at a floor, zero between floors
//   motSube      motor up command (registered)
//   motBaja      motor down command (registered)
//   puerta       door open command (registered)
//   piso_actual  last floor whose switch was seen (registered)
//   pendientes   outstanding calls (registered)
//   falla        fault flag, latched until reset (registered)
module ascensor_planificador #(
    parameter int unsigned N_PISOS   = 4,
    parameter int unsigned T_PUERTA  = 20,
    parameter int unsigned T_TIMEOUT = 200,
    parameter int unsigned W_PISO    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PISOS-1:0] llamada,
    input  logic [N_PISOS-1:0] sw_piso,
    output logic               motSube,
    output logic               motBaja,
    output logic               puerta,
    output logic [W_PISO-1:0]  piso_actual,
    output logic [N_PISOS-1:0] pendientes,
    output logic               falla
);

    localparam int unsigned W_PTA = $clog2(T_PUERTA + 1);
    localparam int unsigned W_WD  = $clog2(T_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_REPOSO   = 3'd1,
        ST_SUBIENDO = 3'd2,
        ST_BAJANDO  = 3'd3,
        ST_PUERTA   = 3'd4,
        ST_FALLA    = 3'd5
    } estado_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    estado_t            state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [N_PISOS-1:0] pend_q, pend_d;
    logic [W_PISO-1:0]  piso_q, piso_d;
    logic [W_PTA-1:0]   cnt_q, cnt_d;
    logic [W_WD-1:0]    wd_q, wd_d;
    logic               mot_sube_q, mot_sube_d;
    logic               mot_baja_q, mot_baja_d;
    logic               puerta_q, puerta_d;
    logic               falla_q, falla_d;

    logic [W_PISO-1:0]  sw_idx_c;
    logic               sw_unico_c;
    logic               sw_multi_c;
    logic [N_PISOS-1:0] limpiar_c;
    logic [N_PISOS-1:0] absorber_c;
    logic [N_PISOS-1:0] delante_c;
    logic               extremo_c;

    // Floors strictly above / below floor p.
    function automatic logic [N_PISOS-1:0] mascara_arriba(input logic [W_PISO-1:0] p);
        logic [N_PISOS-1:0] m;
        for (int unsigned i = 0; i < N_PISOS; i++) begin
            m[i] = (W_PISO'(i) > p);
        end
        return m;
    endfunction

    function automatic logic [N_PISOS-1:0] mascara_abajo(input logic [W_PISO-1:0] p);
        logic [N_PISOS-1:0] m;
        for (int unsigned i = 0; i < N_PISOS; i++) begin
            m[i] = (W_PISO'(i) < p);
        end
        return m;
    endfunction

    // Limit-switch decode: index of the active switch and one-hot / multi-hot flags.
    always_comb begin
        sw_idx_c = '0;
        for (int unsigned i = 0; i < N_PISOS; i++) begin
            if (sw_piso[i]) begin
                sw_idx_c = W_PISO'(i);
            end
        end
        sw_multi_c = ((sw_piso & (sw_piso - N_PISOS'(1))) != '0);
        sw_unico_c = (sw_piso != '0) && !sw_multi_c;
    end

    // Next-state, counters, call register and registered-output values.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        piso_d     = piso_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        limpiar_c  = '0;
        absorber_c = '0;
        delante_c  = '0;
        extremo_c  = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (sw_unico_c) begin
                    piso_d  = sw_idx_c;
                    wd_d    = '0;
                    state_d = ST_REPOSO;
                end else begin
                    // Homing downward, under the same watchdog as normal travel.
                    wd_d = wd_q + W_WD'(1);
                    if (wd_q == W_WD'(T_TIMEOUT - 1)) begin
                        state_d = ST_FALLA;
                    end
                end
            end

            ST_REPOSO: begin
                wd_d  = '0;
                cnt_d = '0;
                if (pend_q[piso_q]) begin
                    limpiar_c = N_PISOS'(1) << piso_q;
                    state_d   = ST_PUERTA;
                end else if (((pend_q & mascara_arriba(piso_q)) != '0) &&
                             ((dir_q == DIR_UP) || ((pend_q & mascara_abajo(piso_q)) == '0))) begin
                    dir_d   = DIR_UP;
                    state_d = ST_SUBIENDO;
                end else if ((pend_q & mascara_abajo(piso_q)) != '0) begin
                    dir_d   = DIR_DOWN;
                    state_d = ST_BAJANDO;
                end
            end

            ST_SUBIENDO, ST_BAJANDO: begin
                if (sw_unico_c && (sw_idx_c != piso_q)) begin
                    piso_d = sw_idx_c;
                    wd_d   = '0;
                    if (state_q == ST_SUBIENDO) begin
                        delante_c = pend_q & mascara_arriba(sw_idx_c);
                        extremo_c = (sw_idx_c == W_PISO'(N_PISOS - 1));
                    end else begin
                        delante_c = pend_q & mascara_abajo(sw_idx_c);
                        extremo_c = (sw_idx_c == '0);
                    end
                    if (pend_q[sw_idx_c]) begin
                        limpiar_c = N_PISOS'(1) << sw_idx_c;
                        cnt_d     = '0;
                        state_d   = ST_PUERTA;
                    end else if ((delante_c == '0) || extremo_c) begin
                        state_d = ST_REPOSO;
                    end
                end else begin
                    wd_d = wd_q + W_WD'(1);
                    if (wd_q == W_WD'(T_TIMEOUT - 1)) begin
                        state_d = ST_FALLA;
                    end
                end
            end

            ST_PUERTA: begin
                // On the closing cycle a call here is latched so REPOSO reopens the door.
                if (cnt_q == W_PTA'(T_PUERTA - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_REPOSO;
                end else if (llamada[piso_q]) begin
                    absorber_c = N_PISOS'(1) << piso_q;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + W_PTA'(1);
                end
            end

            ST_FALLA: begin
                state_d = ST_FALLA;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (sw_multi_c) begin
            state_d = ST_FALLA;
        end

        if (state_q == ST_FALLA) begin
            pend_d = pend_q;
        end else begin
            pend_d = (pend_q | (llamada & ~absorber_c)) & ~limpiar_c;
        end

        mot_sube_d = (state_d == ST_SUBIENDO);
        mot_baja_d = (state_d == ST_BAJANDO) || (state_d == ST_INIT);
        puerta_d   = (state_d == ST_PUERTA);
        falla_d    = (state_d == ST_FALLA);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            dir_q      <= DIR_UP;
            pend_q     <= '0;
            piso_q     <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            mot_sube_q <= 1'b0;
            mot_baja_q <= 1'b0;
            puerta_q   <= 1'b0;
            falla_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            piso_q     <= piso_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            mot_sube_q <= mot_sube_d;
            mot_baja_q <= mot_baja_d;
            puerta_q   <= puerta_d;
            falla_q    <= falla_d;
        end
    end

    assign motSube     = mot_sube_q;
    assign motBaja     = mot_baja_q;
    assign puerta      = puerta_q;
    assign piso_actual = piso_q;
    assign pendientes  = pend_q;
    assign falla       = falla_q;

endmodule

// File: tb/tb_ascensor_planificador.sv
// tb_ascensor_planificador: directed bench for ascensor_planificador (4 floors).
// Expected output snapshots are queued as each step is driven and compared
// against the DUT outputs on the following falling edge.
module tb_ascensor_planificador;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    typedef struct packed {
        logic         sube;
        logic         baja;
        logic         puerta;
        logic         falla;
        logic [W-1:0] piso;
        logic [N-1:0] pend;
    } salida_t;

    typedef struct {
        string   tag;
        salida_t exp;
    } esperado_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] llamada;
    logic [N-1:0] sw_piso;
    logic         motSube;
    logic         motBaja;
    logic         puerta;
    logic [W-1:0] piso_actual;
    logic [N-1:0] pendientes;
    logic         falla;

    esperado_t cola[$];
    int        n_cmp = 0;
    int        n_err = 0;

    ascensor_planificador #(
        .N_PISOS   (N),
        .T_PUERTA  (20),
        .T_TIMEOUT (200),
        .W_PISO    (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .llamada     (llamada),
        .sw_piso     (sw_piso),
        .motSube     (motSube),
        .motBaja     (motBaja),
        .puerta      (puerta),
        .piso_actual (piso_actual),
        .pendientes  (pendientes),
        .falla       (falla)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic salida_t o(input logic s, input logic b, input logic p, input logic f,
                                  input logic [W-1:0] piso, input logic [N-1:0] pend);
        salida_t r;
        r.sube   = s;
        r.baja   = b;
        r.puerta = p;
        r.falla  = f;
        r.piso   = piso;
        r.pend   = pend;
        return r;
    endfunction

    task automatic comparar();
        esperado_t it;
        salida_t   obs;
        it  = cola.pop_front();
        obs = {motSube, motBaja, puerta, falla, piso_actual, pendientes};
        n_cmp++;
        assert (obs === it.exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b (sube,baja,puerta,falla,piso,pend)",
                   it.tag, obs, it.exp);
        end
    endtask

    // Queue the expectation for the current inputs, advance one cycle, then check.
    task automatic ciclo(input string tag, input salida_t e);
        esperado_t it;
        it.tag = tag;
        it.exp = e;
        cola.push_back(it);
        @(negedge clk);
        comparar();
    endtask

    task automatic esperar(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b0;
        llamada = '0;
        sw_piso = '0;
        esperar(2);
        ciclo("reset", o(0, 0, 0, 0, 0, 4'b0000));

        // Homing from between floors.
        reset = 1'b1;
        ciclo("homing", o(0, 1, 0, 0, 0, 4'b0000));
        esperar(9);
        ciclo("homing_hold", o(0, 1, 0, 0, 0, 4'b0000));
        sw_piso = 4'b0001;
        ciclo("home_reposo", o(0, 0, 0, 0, 0, 4'b0000));

        // Run from floor 0 to floor 3, passing 1 and 2.
        llamada = 4'b1000;
        ciclo("call3_latched", o(0, 0, 0, 0, 0, 4'b1000));
        llamada = '0;
        ciclo("up_start", o(1, 0, 0, 0, 0, 4'b1000));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b0010; ciclo("pass_f1", o(1, 0, 0, 0, 1, 4'b1000));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b0100; ciclo("pass_f2", o(1, 0, 0, 0, 2, 4'b1000));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b1000; ciclo("stop_f3", o(0, 0, 1, 0, 3, 4'b0000));
        esperar(18);
        ciclo("door20_open", o(0, 0, 1, 0, 3, 4'b0000));
        ciclo("door20_closed", o(0, 0, 0, 0, 3, 4'b0000));

        // Down to floor 1, then a call at the open door restarts the timer.
        llamada = 4'b0010;
        ciclo("call1_latched", o(0, 0, 0, 0, 3, 4'b0010));
        llamada = '0;
        ciclo("down_start", o(0, 1, 0, 0, 3, 4'b0010));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b0100; ciclo("pass_f2_down", o(0, 1, 0, 0, 2, 4'b0010));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b0010; ciclo("stop_f1", o(0, 0, 1, 0, 1, 4'b0000));
        esperar(5);
        llamada = 4'b0010;
        ciclo("absorb", o(0, 0, 1, 0, 1, 4'b0000));
        llamada = '0;
        esperar(18);
        ciclo("restart_open", o(0, 0, 1, 0, 1, 4'b0000));
        ciclo("restart_closed", o(0, 0, 0, 0, 1, 4'b0000));

        // Up from 1 toward 3; a call at 2 en route stops there first.
        llamada = 4'b1000;
        ciclo("call3_from1", o(0, 0, 0, 0, 1, 4'b1000));
        llamada = '0;
        ciclo("up_from1", o(1, 0, 0, 0, 1, 4'b1000));
        sw_piso = '0; esperar(2);
        llamada = 4'b0100;
        ciclo("call2_en_route", o(1, 0, 0, 0, 1, 4'b1100));
        llamada = '0; esperar(2);
        sw_piso = 4'b0100; ciclo("stop_f2", o(0, 0, 1, 0, 2, 4'b1000));

        // At floor 2 going up with calls at 3 and 0: SCAN serves 3 first.
        llamada = 4'b0001;
        ciclo("call0_during_door", o(0, 0, 1, 0, 2, 4'b1001));
        llamada = '0;
        esperar(18);
        ciclo("door_f2_closed", o(0, 0, 0, 0, 2, 4'b1001));
        ciclo("scan_up_first", o(1, 0, 0, 0, 2, 4'b1001));
        sw_piso = '0;     esperar(3);
        sw_piso = 4'b1000; ciclo("stop_f3_scan", o(0, 0, 1, 0, 3, 4'b0001));
        esperar(19);
        ciclo("door_f3_closed", o(0, 0, 0, 0, 3, 4'b0001));
        ciclo("scan_down", o(0, 1, 0, 0, 3, 4'b0001));
        sw_piso = '0;     esperar(2);
        sw_piso = 4'b0100; ciclo("pass_f2_scan", o(0, 1, 0, 0, 2, 4'b0001));
        sw_piso = '0;     esperar(2);
        sw_piso = 4'b0010; ciclo("pass_f1_scan", o(0, 1, 0, 0, 1, 4'b0001));
        sw_piso = '0;     esperar(2);
        sw_piso = 4'b0001; ciclo("stop_f0_scan", o(0, 0, 1, 0, 0, 4'b0000));

        // Call at the current floor on the closing cycle reopens the door.
        esperar(19);
        llamada = 4'b0001;
        ciclo("close_with_call", o(0, 0, 0, 0, 0, 4'b0001));
        llamada = '0;
        ciclo("reopen", o(0, 0, 1, 0, 0, 4'b0000));
        esperar(19);
        ciclo("reopen_closed", o(0, 0, 0, 0, 0, 4'b0000));

        // Motion watchdog: motor runs with no switch for 200 cycles.
        llamada = 4'b0100;
        ciclo("call2_wd", o(0, 0, 0, 0, 0, 4'b0100));
        llamada = '0;
        ciclo("wd_motor_on", o(1, 0, 0, 0, 0, 4'b0100));
        sw_piso = '0;
        esperar(198);
        ciclo("wd_still_running", o(1, 0, 0, 0, 0, 4'b0100));
        ciclo("wd_fault", o(0, 0, 0, 1, 0, 4'b0100));
        llamada = 4'b1111;
        ciclo("fault_ignores_call", o(0, 0, 0, 1, 0, 4'b0100));
        llamada = '0;
        esperar(5);
        ciclo("fault_latched", o(0, 0, 0, 1, 0, 4'b0100));
        reset = 1'b0;
        ciclo("fault_reset", o(0, 0, 0, 0, 0, 4'b0000));
        reset   = 1'b1;
        sw_piso = 4'b0001;
        ciclo("reinit", o(0, 0, 0, 0, 0, 4'b0000));

        // Multi-hot limit switches force a fault.
        sw_piso = 4'b0110;
        ciclo("multi_sw_fault", o(0, 0, 0, 1, 0, 4'b0000));
        sw_piso = 4'b0001;
        ciclo("multi_sw_latched", o(0, 0, 0, 1, 0, 4'b0000));
        reset = 1'b0;
        ciclo("reset2", o(0, 0, 0, 0, 0, 4'b0000));
        reset = 1'b1;
        ciclo("reinit2", o(0, 0, 0, 0, 0, 4'b0000));

        // Reset mid-travel: motor drops immediately, then homing.
        llamada = 4'b1000;
        ciclo("call3_mid", o(0, 0, 0, 0, 0, 4'b1000));
        llamada = '0;
        ciclo("mid_up", o(1, 0, 0, 0, 0, 4'b1000));
        sw_piso = '0; esperar(3);
        reset = 1'b0;
        ciclo("mid_reset_off", o(0, 0, 0, 0, 0, 4'b0000));
        reset = 1'b1;
        ciclo("mid_homing", o(0, 1, 0, 0, 0, 4'b0000));
        esperar(4);
        sw_piso = 4'b0001;
        ciclo("mid_home", o(0, 0, 0, 0, 0, 4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
